// File: rtl/countdown_arbiter.sv
// countdown_arbiter: round-robin scheduler that lends one shared down counter to NUM_REQ requesters.
module countdown_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_len,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic                     err,
  output logic [WIDTH-1:0]         cnt_in,
  output logic                     cnt_latch,
  output logic                     cnt_dec,
  input  logic                     cnt_zero
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [WIDTH:0] WD_MAX = {1'b1, {WIDTH{1'b0}}};
  typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;
  state_t             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IW-1:0]      idx_q, last_q, pick;
  logic [WIDTH-1:0]   len_q;
  logic [WIDTH:0]     wd_q;
  logic               busy_q, err_q, owned, wd_trip, rel;
  always_comb begin
    pick = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req[(int'(last_q) + k) % NUM_REQ]) pick = IW'((int'(last_q) + k) % NUM_REQ);
  end
  // A job is released on completion, on abort (request dropped) or when the watchdog trips.
  assign owned   = (state_q == LOAD || state_q == COUNT) && req[idx_q];
  assign wd_trip = state_q == COUNT && req[idx_q] && !cnt_zero && wd_q == WD_MAX;
  assign rel     = state_q == DONE || ((state_q == LOAD || state_q == COUNT) && !owned) || wd_trip;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      len_q   <= '0;
      wd_q    <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (rel) begin
      state_q <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      last_q  <= idx_q;
      err_q   <= err_q | wd_trip;
    end else
      case (state_q)
        IDLE: if (|req) begin
          state_q <= LOAD;
          grant_q <= NUM_REQ'(1) << pick;
          idx_q   <= pick;
          len_q   <= req_len[int'(pick)*WIDTH +: WIDTH];
          busy_q  <= 1'b1;
        end
        LOAD: begin
          state_q <= COUNT;
          wd_q    <= '0;
        end
        COUNT: if (cnt_zero) state_q <= DONE; else wd_q <= wd_q + 1'b1;
        default: ;
      endcase
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign cnt_in    = len_q;
  assign cnt_latch = state_q == LOAD;
  assign cnt_dec   = state_q == COUNT && !cnt_zero;
  assign done      = state_q == DONE ? grant_q : '0;
endmodule

// File: tb/tb_countdown_arbiter.sv
// tb_countdown_arbiter: scoreboard bench with a transaction-level round-robin model and an emulated down counter.
module tb_countdown_arbiter;
  localparam int N = 4, W = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] req_len = '0;
  logic [N-1:0] grant, done;
  logic busy, err, cnt_latch, cnt_dec, cnt_zero;
  logic [W-1:0] cnt_in;
  logic [W-1:0] ctr = '0;
  logic stuck = 1'b0;
  int checks = 0, failures = 0, cyc = 0, g_start = 0, model_last = N - 1;
  logic [N-1:0] grant_prev = '0;
  typedef struct {int idx; int len;} job_t;
  job_t exp_q[$];

  countdown_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .grant(grant), .done(done),
    .busy(busy), .err(err), .cnt_in(cnt_in), .cnt_latch(cnt_latch), .cnt_dec(cnt_dec),
    .cnt_zero(cnt_zero));

  always #5 clk = ~clk;

  // Shared Down_Counter emulation; stuck forces the zero flag low for the watchdog test.
  assign cnt_zero = !stuck && ctr == '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cnt_latch) ctr <= cnt_in;
    else if (cnt_dec) ctr <= ctr - 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst) grant_prev = '0;
    else begin
      if ((grant & ~grant_prev) != '0) g_start = cyc;
      grant_prev = grant;
      if (cnt_latch && exp_q.size() > 0) check("latch_len", 32'(cnt_in), exp_q[0].len);
      if (cnt_dec && (cnt_latch || cnt_zero)) check("dec_illegal", 32'(cnt_dec), 0);
      if ($countones(grant) > 1) check("grant_onehot", 32'(grant), 0);
      if ((done & ~grant) != '0) check("done_without_grant", 32'(done), 32'(grant));
      if (done != '0) begin
        if (exp_q.size() == 0) check("unexpected_done", 32'(done), 0);
        else begin
          job_t j;
          j = exp_q.pop_front();
          check("done_idx", 32'(done), 32'(1) << j.idx);
          check("done_latency", cyc - g_start, j.len + 2);
        end
      end
    end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    if (busy) check("idle_timeout", 32'(busy), 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((req != '0 || busy) && n < 400) begin
      @(negedge clk);
      req = req & ~done;
      n++;
    end
    check("drain", {req, busy}, 0);
  endtask

  task automatic wait_latch();
    int n = 0;
    while (!cnt_latch && n < 20) begin @(negedge clk); n++; end
    if (!cnt_latch) check("latch_timeout", 32'(cnt_latch), 1);
  endtask

  // Expected service order: pending requesters scanned from last+1 with wrap.
  task automatic run_round(input logic [N-1:0] mask, input logic [N*W-1:0] lens);
    int s;
    @(negedge clk);
    wait_idle();
    req_len = lens;
    s = model_last;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (s + k) % N;
      if (mask[i]) begin
        exp_q.push_back('{i, int'(lens[i*W +: W])});
        model_last = i;
      end
    end
    req = mask;
    drain();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    exp_q.delete();
    model_last = N - 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int dec, n;
    repeat (3) @(negedge clk);
    check("reset_out", {grant, done, busy, err, cnt_latch, cnt_dec, cnt_in}, 0);
    rst = 1'b0;
    run_round(4'b0001, 16'h000F);
    run_round(4'b0100, 16'h0000);
    run_round(4'b1111, 16'h2222);
    // Abort requester 1 mid-count while requester 3 waits.
    wait_idle();
    req_len = 16'h5090;
    req = 4'b0010;
    @(negedge clk);
    wait_latch();
    check("abort_grant", 32'(grant), 32'b0010);
    repeat (3) @(negedge clk);
    check("abort_counting", 32'(cnt_dec), 1);
    req = 4'b1000;
    exp_q.push_back('{3, 5});
    model_last = 3;
    @(negedge clk);
    check("abort_release", {grant, busy}, 0);
    @(negedge clk);
    check("abort_next", 32'(grant), 32'b1000);
    drain();
    // Asynchronous reset in the middle of a countdown.
    wait_idle();
    req_len = 16'h0009;
    req = 4'b0001;
    exp_q.push_back('{0, 9});
    @(negedge clk);
    wait_latch();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_async", {grant, done, busy, err, cnt_latch, cnt_dec, cnt_in}, 0);
    req = '0;
    exp_q.delete();
    model_last = N - 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_round(4'b1010, 16'h3040);
    // Watchdog with the zero flag stuck low.
    wait_idle();
    stuck = 1'b1;
    req_len = 16'h0003;
    req = 4'b0001;
    dec = 0;
    n = 0;
    while (!err && n < 60) begin
      @(negedge clk);
      if (cnt_dec) dec++;
      n++;
    end
    req = '0;
    model_last = 0;
    check("wd_err", 32'(err), 1);
    check("wd_cycles", dec, 17);
    check("wd_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    check("wd_sticky", {err, busy, grant}, 32'h20);
    stuck = 1'b0;
    run_round(4'b0010, 16'h0040);
    check("err_held", 32'(err), 1);
    pulse_reset();
    check("err_cleared", 32'(err), 0);
    for (int r = 0; r < 30; r++)
      run_round(N'($urandom_range(1, (1 << N) - 1)), (N*W)'($urandom));
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
